reception_fifo_module: RTL and testbench

- Receiving end of the en/sda/scl serial link driven by transmission_module.
- Deserialises MSB-first frames, checks length (and optionally parity), and buffers complete words in a small FIFO.
- Exposes a valid/ready read port to the consumer.
- Drives hold_o back to the transmitter side as flow control when the buffer nears full.

---
 rtl/reception_fifo_module.sv | 154 +++++++++++++++
 tb/tb_reception_fifo_module.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/reception_fifo_module.sv
// Serial link receiver: deserialises MSB-first en/sda/scl frames and buffers words in a FIFO.
// Optional even-parity bit after the payload when RECEPTION_PARITY_EN is defined.
module reception_fifo_module #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  sda_i,
  input  logic                  scl_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  hold_o,
  output logic                  err_o,
  output logic                  ovf_o
);

`ifdef RECEPTION_PARITY_EN
  localparam int FRAME_BITS = DATA_WIDTH + 1;
`else
  localparam int FRAME_BITS = DATA_WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_HOLD = OCC_W'(FIFO_DEPTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  en_q, scl_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  hold_q, err_q, ovf_q;
  logic                  err_d, ovf_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                  en_rise, en_fall, scl_rise;
  logic                  frame_ok, push, pop, full, parity_ok;
  logic [DATA_WIDTH-1:0] payload;

  assign en_rise  = en_i & ~en_q;
  assign en_fall  = ~en_i & en_q;
  assign scl_rise = scl_i & ~scl_q;

`ifdef RECEPTION_PARITY_EN
  // Even parity: payload bits XOR parity bit must be zero.
  assign payload   = shift_q[FRAME_BITS-1:1];
  assign parity_ok = ~(^shift_q);
`else
  assign payload   = shift_q;
  assign parity_ok = 1'b1;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    frame_ok = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_rise) begin
          cnt_d   = '0;
          shift_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (en_fall) begin
          state_d = CHECK;
        end else if (en_i && scl_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], sda_i};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        state_d  = IDLE;
        frame_ok = (cnt_q == CNT_FULL) && parity_ok;
        err_d    = ~frame_ok;
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign full     = (occ_q == OCC_MAX);
  assign pop      = valid_o & ready_i;
  assign push     = frame_ok & (~full | pop);
  assign ovf_d    = frame_ok & full & ~pop;
  assign wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      en_q     <= 1'b1;
      scl_q    <= 1'b1;
      cnt_q    <= '0;
      shift_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_i;
      scl_q    <= scl_i;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      hold_q   <= (occ_d >= OCC_HOLD);
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is not reset; data_o is masked while empty so stale or X contents never leak out.
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) mem_q[wr_ptr_q] <= payload;
  end

  assign valid_o = (occ_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign hold_o  = hold_q;
  assign err_o   = err_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_reception_fifo_module.sv
// Directed bench for reception_fifo_module (DATA_WIDTH=8, FIFO_DEPTH=4); parity cases run when RECEPTION_PARITY_EN is defined.
module tb_reception_fifo_module;

`ifdef RECEPTION_PARITY_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif

  logic       clk_i = 1'b0;
  logic       reset_i, en_i, sda_i, scl_i, ready_i;
  logic [7:0] data_o;
  logic       valid_o, hold_o, err_o, ovf_o;
  logic       pre_valid;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk_i = ~clk_i;

  reception_fifo_module #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .sda_i(sda_i), .scl_i(scl_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .hold_o(hold_o),
    .err_o(err_o), .ovf_o(ovf_o)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [7:0] w);
`ifdef RECEPTION_PARITY_EN
    return {7'b0, w, ^w};
`else
    return {8'b0, w};
`endif
  endfunction

  // Sends nedges bits of frame MSB first; returns in the cycle after CHECK.
  task automatic send_raw(input logic [15:0] frame, input int nedges, input logic pop_in_check);
    en_i = 1'b1; tick();
    for (int i = nedges - 1; i >= 0; i--) begin
      sda_i = frame[i]; scl_i = 1'b0; tick();
      scl_i = 1'b1; tick();
    end
    scl_i = 1'b0; tick();
    en_i = 1'b0; tick();
    pre_valid = valid_o;
    ready_i = pop_in_check; tick();
    ready_i = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic pop_in_check);
    send_raw(mk(w), FB, pop_in_check);
  endtask

  task automatic pop_one();
    ready_i = 1'b1; tick();
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; en_i = 1'b0; sda_i = 1'b0; scl_i = 1'b0; ready_i = 1'b0;
    tick(); tick();
    reset_i = 1'b0; tick();
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data_o); end
    n_cmp++; if ({hold_o, err_o, ovf_o} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {hold_o, err_o, ovf_o}); end
  endtask

  task automatic test_single();
    send_word(8'h90, 1'b0);
    n_cmp++; if (pre_valid !== 1'b0) begin n_bad++; $display("FAIL single_early: valid in CHECK got %b want 0", pre_valid); end
    n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", valid_o); end
    n_cmp++; if (data_o !== 8'h90) begin n_bad++; $display("FAIL single_data: got %h want 90", data_o); end
    n_cmp++; if ({err_o, ovf_o} !== 2'b00) begin n_bad++; $display("FAIL single_flags: got %b want 00", {err_o, ovf_o}); end
    pop_one();
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL single_pop: valid got %b want 0", valid_o); end
    tick();
  endtask

  task automatic test_two();
    send_word(8'h90, 1'b0); tick();
    send_word(8'h81, 1'b0); tick();
    n_cmp++; if (hold_o !== 1'b0) begin n_bad++; $display("FAIL two_hold: got %b want 0", hold_o); end
    n_cmp++; if (data_o !== 8'h90) begin n_bad++; $display("FAIL two_head0: got %h want 90", data_o); end
    pop_one();
    n_cmp++; if (valid_o !== 1'b1 || data_o !== 8'h81) begin n_bad++; $display("FAIL two_head1: got %b/%h want 1/81", valid_o, data_o); end
    pop_one();
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL two_empty: valid got %b want 0", valid_o); end
    tick();
  endtask

  task automatic test_full();
    for (int i = 1; i <= 5; i++) begin
      send_word(8'(i), 1'b0);
      n_cmp++; if (hold_o !== (i >= 3)) begin n_bad++; $display("FAIL full_hold%0d: got %b want %b", i, hold_o, (i >= 3)); end
      n_cmp++; if (ovf_o !== (i == 5)) begin n_bad++; $display("FAIL full_ovf%0d: got %b want %b", i, ovf_o, (i == 5)); end
      tick();
    end
    n_cmp++; if (ovf_o !== 1'b0) begin n_bad++; $display("FAIL full_ovf_pulse: got %b want 0", ovf_o); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (valid_o !== 1'b1 || data_o !== 8'(i)) begin n_bad++; $display("FAIL full_read%0d: got %b/%h want 1/%h", i, valid_o, data_o, 8'(i)); end
      pop_one();
      n_cmp++; if (hold_o !== (i == 1)) begin n_bad++; $display("FAIL full_hold_drain%0d: got %b want %b", i, hold_o, (i == 1)); end
    end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL full_empty: valid got %b want 0", valid_o); end
    tick();
  endtask

  task automatic test_push_pop_full();
    for (int i = 1; i <= 4; i++) begin send_word(8'(i), 1'b0); tick(); end
    send_word(8'h05, 1'b1);
    n_cmp++; if (ovf_o !== 1'b0) begin n_bad++; $display("FAIL pp_ovf: got %b want 0", ovf_o); end
    n_cmp++; if (data_o !== 8'h02 || hold_o !== 1'b1) begin n_bad++; $display("FAIL pp_head: got %h/%b want 02/1", data_o, hold_o); end
    for (int i = 2; i <= 5; i++) begin
      n_cmp++; if (data_o !== 8'(i)) begin n_bad++; $display("FAIL pp_read%0d: got %h want %h", i, data_o, 8'(i)); end
      pop_one();
    end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL pp_empty: valid got %b want 0", valid_o); end
    tick();
  endtask

  task automatic test_length();
    send_raw(16'h00AA, 6, 1'b0);
    n_cmp++; if (err_o !== 1'b1 || valid_o !== 1'b0) begin n_bad++; $display("FAIL len_short: err/valid got %b/%b want 1/0", err_o, valid_o); end
    tick();
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL len_pulse: err got %b want 0", err_o); end
    send_raw(16'h01AA, FB + 1, 1'b0);
    n_cmp++; if (err_o !== 1'b1 || valid_o !== 1'b0) begin n_bad++; $display("FAIL len_long: err/valid got %b/%b want 1/0", err_o, valid_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic bad;
    bad = 1'b0;
    en_i = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      sda_i = 1'b1; scl_i = 1'b0; tick();
      scl_i = 1'b1; tick();
    end
    reset_i = 1'b1; scl_i = 1'b0; tick();
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      scl_i = 1'b1; tick(); bad |= (err_o !== 1'b0) || (valid_o !== 1'b0);
      scl_i = 1'b0; tick(); bad |= (err_o !== 1'b0) || (valid_o !== 1'b0);
    end
    en_i = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); bad |= (err_o !== 1'b0) || (valid_o !== 1'b0); end
    n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL rst_mid_quiet: stray err/valid seen got %b want 0", bad); end
    send_word(8'hA5, 1'b0);
    n_cmp++; if (valid_o !== 1'b1 || data_o !== 8'hA5 || err_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_a5: got %b/%h/%b want 1/a5/0", valid_o, data_o, err_o); end
    pop_one(); tick();
  endtask

`ifdef RECEPTION_PARITY_EN
  task automatic test_parity();
    send_raw({7'b0, 8'h90, 1'b0}, 9, 1'b0);
    n_cmp++; if (valid_o !== 1'b1 || data_o !== 8'h90 || err_o !== 1'b0) begin n_bad++; $display("FAIL par_good: got %b/%h/%b want 1/90/0", valid_o, data_o, err_o); end
    pop_one(); tick();
    send_raw({7'b0, 8'h90, 1'b1}, 9, 1'b0);
    n_cmp++; if (valid_o !== 1'b0 || err_o !== 1'b1) begin n_bad++; $display("FAIL par_bad: valid/err got %b/%b want 0/1", valid_o, err_o); end
    tick();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation ran past time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_two();
    test_full();
    test_push_pop_full();
    test_length();
    test_reset_mid();
`ifdef RECEPTION_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
